elevator_ctrl: RTL and testbench
================================

ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 Parameter NUM_FLOORS, default 4, number of served floors (legal 2..16).
REQ-002 Parameter MOVE_CYCLES, default 2, clock cycles to travel one floor (legal 1..255).
REQ-003 Parameter DOOR_CYCLES, default 4, clock cycles the door stays open (legal 1..255).
REQ-004 Derived constant FLOOR_W = clog2(NUM_FLOORS), minimum 1; it is not user-overridable.
REQ-005 CLK  input  1  single clock; all state updates on the rising edge.
REQ-006 RST  input  1  reset, synchronous and active-high.
REQ-007 req  input  NUM_FLOORS  call buttons; bit i = call to floor i; pulse or level accepted.
REQ-008 stop_go  input  1  1 = hold (freeze motion and timers); 0 = run.
REQ-009 output_floor  output  FLOOR_W  current floor, binary.
REQ-010 pending  output  NUM_FLOORS  latched outstanding calls.
REQ-011 moving  output  1  high while state is MOVE.
REQ-012 dir_up  output  1  current/last travel direction; 1 = up.
REQ-013 door_open  output  1  high while state is DOOR.

Function
REQ-014 The FSM SHALL have three states: IDLE, MOVE and DOOR; all outputs are registered or decoded from registered state only.
REQ-015 For each rising edge with RST=0, pending SHALL be updated as pending | req, except that a bit cleared by REQ-019 on the same edge wins over that floor's req bit.
REQ-016 The FSM SHALL act on the registered pending, so a call sampled at edge k is acted on at edge k+1 at the earliest.
REQ-017 In IDLE:
- If pending[output_floor]=1, the FSM SHALL go to DOOR.
- Otherwise, if calls exist both above and below, it SHALL go to MOVE keeping dir_up.
- Otherwise, if calls exist only above or only below, it SHALL go to MOVE with dir_up set toward them.
- With no calls, it SHALL stay in IDLE.
REQ-018 Each floor in MOVE SHALL last exactly MOVE_CYCLES cycles:
- At the end of that floor, output_floor SHALL step by +1 (dir_up=1) or -1 (dir_up=0).
- If pending at the new floor is set, the FSM SHALL go to DOOR; otherwise it SHALL start the next floor in the same direction.
REQ-019 On entry to DOOR, pending[output_floor] SHALL be cleared and the door timer loaded with DOOR_CYCLES; door_open SHALL be high for exactly DOOR_CYCLES cycles.
REQ-020 A call to output_floor arriving during DOOR SHALL be absorbed: the bit is not set and the door timer reloads to DOOR_CYCLES.
REQ-021 At the end of DOOR, the FSM SHALL choose the next state with the REQ-017 rules:
- If calls remain in dir_up, it continues in that direction.
- Else if calls remain opposite, it reverses.
- Else it goes to IDLE.
REQ-022 output_floor SHALL never step below 0 or above NUM_FLOORS-1; MOVE toward a bound with no call beyond it SHALL not occur.
REQ-023 While stop_go=1, state, output_floor, dir_up and both timers SHALL hold, and pending SHALL still accumulate calls; operation SHALL resume on the first edge with stop_go=0.
REQ-024 Simultaneous calls at several floors SHALL be served in sweep order: all calls ahead in dir_up are served first, then the direction reverses.

Reset
REQ-025 With RST=1 at a rising edge, the block SHALL set:
- state=IDLE;
- output_floor=0;
- pending=0;
- dir_up=1;
- moving=0;
- door_open=0;
- timers=0.
RST SHALL override stop_go and req.
REQ-026 A reset asserted mid-MOVE or mid-DOOR SHALL take effect at that edge, and all calls latched before it SHALL be discarded.

Structure
REQ-027 The shared package elevator_pkg SHALL hold the state encoding (IDLE=2'b00, MOVE=2'b01, DOOR=2'b10) and the clog2 helper function.
REQ-028 One sub-module, elevator_timer, SHALL be used: a loadable 8-bit down-counter with load, enable (=~stop_go) and a zero flag, shared by the move and door timing.
REQ-029 The top level SHALL contain only the FSM, the pending register and the above/below call-detection logic.

Verification
REQ-030 Reset: after RST=1 for one edge, the bench checks output_floor=0, pending=0, dir_up=1, moving=0 and door_open=0.
REQ-031 Single call (defaults): a pulse req=4'b0100 at floor 0 SHALL produce the following, then the return to IDLE:
- moving=1 for 4 cycles;
- output_floor steps 0->1->2;
- door_open=1 for 4 cycles;
- pending[2]=0.
REQ-032 Same-floor call: req=4'b0001 in IDLE at floor 0 -> DOOR with no motion; a repeat req[0] during DOOR reloads the door timer, giving door_open=1 for 4 cycles after the last press.
REQ-033 Sweep: at floor 1 moving up, calls to floors 0 and 3 -> floor 3 is served first, then floor 0; dir_up goes 1->0 after floor 3.
REQ-034 Hold: stop_go=1 for 10 cycles mid-MOVE, with req[3] pulsed -> output_floor and moving frozen and pending[3]=1; travel timing resumes unchanged once stop_go=0.
REQ-035 Reset mid-operation and NUM_FLOORS=8 build: RST during DOOR at floor 5 -> the next cycle shows floor 0 and IDLE; a call to floor 7 is then reached after 7*MOVE_CYCLES cycles, with no overshoot.

Source files
------------

// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types and helpers for the elevator controller
// Purpose : FSM state encoding, timer width and the floor-index width helper.
// Ports   : none (package).
package elevator_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      MOVE = 2'b01,
      DOOR = 2'b10
   } state_t;

   localparam int TIMER_W = 8;

   // Ceiling log2 with a floor of 1 so a 2-floor build still gets a 1-bit index.
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/elevator_timer.sv
// rtl/elevator_timer.sv - loadable 8-bit down-counter shared by move and door timing
// Purpose : counts down to zero and parks there; load wins over counting.
// Ports   : CLK, RST (sync, active-high), en (count/load enable),
//           load, load_val (value to load), zero (count is zero).
module elevator_timer
   import elevator_pkg::*;
(
   input  logic               CLK,
   input  logic               RST,
   input  logic               en,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_val,
   output logic               zero
);

   logic [TIMER_W-1:0] count;

   always_ff @(posedge CLK) begin
      if (RST) begin
         count <= '0;
      end else if (en) begin
         if (load) begin
            count <= load_val;
         end else if (count != '0) begin
            count <= count - TIMER_W'(1);
         end
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/elevator_ctrl.sv
// rtl/elevator_ctrl.sv - sweep-order elevator controller
// Purpose : latches floor calls and serves them in sweep order with a
//           three-state FSM (IDLE/MOVE/DOOR) and one shared phase timer.
// Ports   : CLK, RST (sync, active-high), req (call buttons, one per floor),
//           stop_go (1 = hold), output_floor (current floor), pending (latched
//           calls), moving, dir_up, door_open.
module elevator_ctrl
   import elevator_pkg::*;
#(
   parameter  int NUM_FLOORS  = 4,
   parameter  int MOVE_CYCLES = 2,
   parameter  int DOOR_CYCLES = 4,
   localparam int FLOOR_W     = clog2(NUM_FLOORS)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [NUM_FLOORS-1:0] req,
   input  logic                  stop_go,
   output logic [FLOOR_W-1:0]    output_floor,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  moving,
   output logic                  dir_up,
   output logic                  door_open
);

   // The timer is loaded with N-1 so its zero flag marks the last of N cycles.
   localparam logic [TIMER_W-1:0] MOVE_LD = TIMER_W'(MOVE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] DOOR_LD = TIMER_W'(DOOR_CYCLES - 1);

   state_t                state;
   state_t                state_nxt;
   logic [FLOOR_W-1:0]    floor_nxt;
   logic [FLOOR_W-1:0]    floor_step;
   logic                  dir_nxt;
   logic                  enter_door;
   logic                  calls_above;
   logic                  calls_below;
   logic [NUM_FLOORS-1:0] clr_mask;
   logic [NUM_FLOORS-1:0] pending_d;
   logic                  tmr_load;
   logic [TIMER_W-1:0]    tmr_val;
   logic                  tmr_zero;

   elevator_timer u_timer (
      .CLK      (CLK),
      .RST      (RST),
      .en       (~stop_go),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_comb begin
      calls_above = 1'b0;
      calls_below = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (pending[i] && (i > int'(output_floor))) calls_above = 1'b1;
         if (pending[i] && (i < int'(output_floor))) calls_below = 1'b1;
      end
   end

   assign floor_step = dir_up ? output_floor + FLOOR_W'(1) : output_floor - FLOOR_W'(1);

   always_comb begin
      state_nxt  = state;
      floor_nxt  = output_floor;
      dir_nxt    = dir_up;
      enter_door = 1'b0;
      tmr_load   = 1'b0;
      tmr_val    = '0;
      if (!stop_go) begin
         case (state)
            IDLE: begin
               if (pending[output_floor]) begin
                  state_nxt  = DOOR;
                  enter_door = 1'b1;
                  tmr_load   = 1'b1;
                  tmr_val    = DOOR_LD;
               end else if (calls_above || calls_below) begin
                  state_nxt = MOVE;
                  tmr_load  = 1'b1;
                  tmr_val   = MOVE_LD;
                  // With calls on both sides the current sweep direction is kept.
                  if (!(calls_above && calls_below)) dir_nxt = calls_above;
               end
            end
            MOVE: begin
               if (tmr_zero) begin
                  floor_nxt = floor_step;
                  tmr_load  = 1'b1;
                  if (pending[floor_step]) begin
                     state_nxt  = DOOR;
                     enter_door = 1'b1;
                     tmr_val    = DOOR_LD;
                  end else begin
                     tmr_val = MOVE_LD;
                  end
               end
            end
            DOOR: begin
               // A fresh press at this floor keeps the door open instead of closing.
               if (req[output_floor]) begin
                  tmr_load = 1'b1;
                  tmr_val  = DOOR_LD;
               end else if (tmr_zero) begin
                  if (dir_up ? calls_above : calls_below) begin
                     state_nxt = MOVE;
                     tmr_load  = 1'b1;
                     tmr_val   = MOVE_LD;
                  end else if (dir_up ? calls_below : calls_above) begin
                     state_nxt = MOVE;
                     dir_nxt   = ~dir_up;
                     tmr_load  = 1'b1;
                     tmr_val   = MOVE_LD;
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // The served floor's bit is cleared on door entry and kept clear while the
   // door is open, even during a hold, so same-floor calls are absorbed.
   always_comb begin
      clr_mask = '0;
      if (enter_door || (state == DOOR)) clr_mask[floor_nxt] = 1'b1;
   end

   assign pending_d = (pending | req) & ~clr_mask;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= IDLE;
         output_floor <= '0;
         pending      <= '0;
         dir_up       <= 1'b1;
      end else begin
         state        <= state_nxt;
         output_floor <= floor_nxt;
         pending      <= pending_d;
         dir_up       <= dir_nxt;
      end
   end

   assign moving    = (state == MOVE);
   assign door_open = (state == DOOR);

endmodule

// File: tb/tb_elevator_ctrl.sv
// tb/tb_elevator_ctrl.sv - randomized and directed checks of elevator_ctrl against a behavioural model
module tb_elevator_ctrl;

   localparam int MOVE_C = 2;
   localparam int DOOR_C = 4;

   logic       clk = 1'b0;
   logic       rst0, rst1, sg0, sg1;
   logic [3:0] req0;
   logic [7:0] req1;
   logic [1:0] floor4;
   logic [2:0] floor8;
   logic [3:0] pend4;
   logic [7:0] pend8;
   logic       mv4, du4, do4, mv8, du8, do8;

   int total = 0;
   int bad   = 0;

   // Behavioural model: one slot per instance (0 = 4 floors, 1 = 8 floors).
   int        m_floor[2];
   bit        m_dir[2];
   bit        m_mv[2];
   bit        m_dr[2];
   int        m_rem[2];
   bit [15:0] m_pend[2];

   always #5 clk = ~clk;

   elevator_ctrl u_dut4 (
      .CLK(clk), .RST(rst0), .req(req0), .stop_go(sg0),
      .output_floor(floor4), .pending(pend4), .moving(mv4),
      .dir_up(du4), .door_open(do4)
   );

   elevator_ctrl #(.NUM_FLOORS(8), .MOVE_CYCLES(MOVE_C), .DOOR_CYCLES(DOOR_C)) u_dut8 (
      .CLK(clk), .RST(rst1), .req(req1), .stop_go(sg1),
      .output_floor(floor8), .pending(pend8), .moving(mv8),
      .dir_up(du8), .door_open(do8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int nf(input int i);
      return (i == 0) ? 4 : 8;
   endfunction

   function automatic bit beyond(input int i, input bit up);
      for (int f = 0; f < nf(i); f++)
         if (m_pend[i][f] && (up ? (f > m_floor[i]) : (f < m_floor[i]))) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_step(input int i, input bit rst, input bit sg, input logic [15:0] rq);
      bit [15:0] nw;
      bit        up, dn;
      int        f;
      if (rst) begin
         m_floor[i] = 0; m_dir[i] = 1'b1; m_mv[i] = 1'b0; m_dr[i] = 1'b0;
         m_rem[i] = 0; m_pend[i] = '0;
         return;
      end
      up = beyond(i, 1'b1);
      dn = beyond(i, 1'b0);
      nw = (m_pend[i] | rq) & 16'((32'h1 << nf(i)) - 1);
      f  = m_floor[i];
      if (m_dr[i]) nw[f] = 1'b0;
      if (!sg) begin
         if (!m_mv[i] && !m_dr[i]) begin
            if (m_pend[i][f]) begin
               m_dr[i] = 1'b1; m_rem[i] = DOOR_C; nw[f] = 1'b0;
            end else if (up || dn) begin
               m_mv[i] = 1'b1; m_rem[i] = MOVE_C;
               if (!(up && dn)) m_dir[i] = up;
            end
         end else if (m_mv[i]) begin
            m_rem[i]--;
            if (m_rem[i] == 0) begin
               f = m_dir[i] ? f + 1 : f - 1;
               m_floor[i] = f;
               if (m_pend[i][f]) begin
                  m_mv[i] = 1'b0; m_dr[i] = 1'b1; m_rem[i] = DOOR_C; nw[f] = 1'b0;
               end else begin
                  m_rem[i] = MOVE_C;
               end
            end
         end else begin
            if (rq[f]) begin
               m_rem[i] = DOOR_C;
            end else begin
               m_rem[i]--;
               if (m_rem[i] == 0) begin
                  m_dr[i] = 1'b0;
                  if (m_dir[i] ? up : dn) begin
                     m_mv[i] = 1'b1; m_rem[i] = MOVE_C;
                  end else if (m_dir[i] ? dn : up) begin
                     m_dir[i] = ~m_dir[i]; m_mv[i] = 1'b1; m_rem[i] = MOVE_C;
                  end
               end
            end
         end
      end
      m_pend[i] = nw;
   endtask

   // One clock: model advances at the rising edge, outputs compared at the falling edge.
   task automatic cycle();
      @(posedge clk);
      model_step(0, rst0, sg0, {12'b0, req0});
      model_step(1, rst1, sg1, {8'b0, req1});
      @(negedge clk);
      check("floor4", floor4, m_floor[0]);
      check("pend4",  pend4,  m_pend[0]);
      check("mv4",    mv4,    m_mv[0]);
      check("dir4",   du4,    m_dir[0]);
      check("door4",  do4,    m_dr[0]);
      check("floor8", floor8, m_floor[1]);
      check("pend8",  pend8,  m_pend[1]);
      check("mv8",    mv8,    m_mv[1]);
      check("dir8",   du8,    m_dir[1]);
      check("door8",  do8,    m_dr[1]);
   endtask

   initial begin
      int mcnt, dcnt, maxf, found, start, reached, f0, ndoor;
      int door_floor[2];
      int door_dir[2];
      bit prev_door;

      rst0 = 1'b1; rst1 = 1'b1; sg0 = 1'b0; sg1 = 1'b0; req0 = '0; req1 = '0;
      @(negedge clk);
      cycle();
      check("rst_floor", floor4, 0);
      check("rst_pend",  pend4,  0);
      check("rst_dir",   du4,    1);
      check("rst_mv",    mv4,    0);
      check("rst_door",  do4,    0);
      rst0 = 1'b0; rst1 = 1'b0;

      // Single call to floor 2 from floor 0.
      req0 = 4'b0100; cycle(); req0 = '0;
      mcnt = 0; dcnt = 0; maxf = 0;
      repeat (14) begin
         cycle();
         mcnt += mv4; dcnt += do4;
         if (floor4 > maxf) maxf = floor4;
      end
      check("single_move_cycles", mcnt, 4);
      check("single_door_cycles", dcnt, 4);
      check("single_max_floor",   maxf, 2);
      check("single_end_floor",   floor4, 2);
      check("single_pend2",       pend4[2], 0);

      // Same-floor call with a repeat press during DOOR.
      rst0 = 1'b1; cycle(); rst0 = 1'b0;
      req0 = 4'b0001; cycle(); req0 = '0;
      cycle(); cycle();
      check("same_door_open", do4, 1);
      req0 = 4'b0001; cycle(); req0 = '0;
      dcnt = do4; mcnt = mv4;
      repeat (10) begin
         cycle();
         dcnt += do4; mcnt += mv4;
      end
      check("same_door_after_press", dcnt, 4);
      check("same_no_motion", mcnt, 0);
      check("same_pend0", pend4[0], 0);

      // Sweep: at floor 1 moving up, calls to 0 and 3.
      req0 = 4'b1000; cycle(); req0 = '0;
      found = 0;
      for (int t = 0; t < 20 && found == 0; t++) begin
         cycle();
         if (floor4 == 1 && mv4) found = 1;
      end
      check("sweep_at_floor1", found, 1);
      req0 = 4'b0001; cycle(); req0 = '0;
      ndoor = 0; prev_door = do4; door_floor = '{-1, -1}; door_dir = '{-1, -1};
      repeat (40) begin
         cycle();
         if (do4 && !prev_door && ndoor < 2) begin
            door_floor[ndoor] = floor4; door_dir[ndoor] = du4; ndoor++;
         end
         prev_door = do4;
      end
      check("sweep_first",     door_floor[0], 3);
      check("sweep_first_dir", door_dir[0],   1);
      check("sweep_second",    door_floor[1], 0);
      check("sweep_rev_dir",   door_dir[1],   0);

      // Hold mid-MOVE with a call to floor 3 during the hold.
      req0 = 4'b0100; cycle(); req0 = '0;
      cycle(); cycle();
      f0 = floor4;
      sg0 = 1'b1;
      for (int t = 0; t < 10; t++) begin
         req0 = (t == 4) ? 4'b1000 : 4'b0000;
         cycle();
      end
      req0 = '0;
      check("hold_floor",  floor4, f0);
      check("hold_moving", mv4, 1);
      check("hold_pend3",  pend4[3], 1);
      sg0 = 1'b0;
      cycle();
      check("hold_resume_step", floor4, f0 + 1);
      repeat (30) cycle();

      // Eight-floor build: reset during DOOR at floor 5, then a call to floor 7.
      req1 = 8'h20; cycle(); req1 = '0;
      found = 0;
      for (int t = 0; t < 40 && found == 0; t++) begin
         cycle();
         if (do8) found = 1;
      end
      check("f8_door_reached", found, 1);
      check("f8_door_floor", floor8, 5);
      rst1 = 1'b1; cycle(); rst1 = 1'b0;
      check("f8_rst_floor", floor8, 0);
      check("f8_rst_idle",  {mv8, do8}, 0);
      check("f8_rst_pend",  pend8, 0);
      req1 = 8'h80; cycle(); req1 = '0;
      start = -1; reached = -1;
      for (int t = 1; t <= 40; t++) begin
         cycle();
         if (mv8 && start < 0) start = t;
         if (floor8 == 7 && reached < 0) reached = t;
      end
      check("f8_travel_cycles", reached - start, 7 * MOVE_C);
      check("f8_end_floor", floor8, 7);

      // Randomized traffic on both instances.
      for (int t = 0; t < 3000; t++) begin
         req0 = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
         req1 = ($urandom_range(0, 5) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'b0;
         sg0  = ($urandom_range(0, 9) == 0);
         sg1  = ($urandom_range(0, 9) == 0);
         rst0 = ($urandom_range(0, 499) == 0);
         rst1 = ($urandom_range(0, 499) == 0);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
